// File: rtl/bin2display_pkg.sv
// Shared constants, state encoding and nibble decode for the sequential
// binary-to-seven-segment driver.
package bin2display_pkg;

  // Active-low segment patterns, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2display_seq_if.sv
// Request/result bundle between a score counter (master) and the display
// driver (slave).
interface bin2display_seq_if #(
  parameter int BIN_WIDTH = 10,
  parameter int DIGITS    = 3
);
  logic                   start;
  logic [BIN_WIDTH-1:0]   valor;
  logic                   busy;
  logic                   done;
  logic                   overflow;
  logic [7*DIGITS-1:0]    digitos;

  modport master (output start, valor, input busy, done, overflow, digitos);
  modport slave  (input start, valor, output busy, done, overflow, digitos);
endinterface

// File: rtl/seg7_digit.sv
// One active-low seven-segment digit: BCD nibble plus a blank request.
module seg7_digit
  import bin2display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  assign seg_o = blank_i ? SEG_BLANK : seg_decode(nibble_i);
endmodule

// File: rtl/bin2display_seq.sv
// Iterative double-dabble converter (one bit per clock) driving DIGITS
// active-low seven-segment digits with leading-zero blanking and overflow.
module bin2display_seq
  import bin2display_pkg::*;
#(
  parameter int BIN_WIDTH   = 10,
  parameter int DIGITS      = 3,
  parameter int BLANK_ZEROS = 1
) (
  input  logic             clk,
  input  logic             reset,
  bin2display_seq_if.slave bus
);
  // One guard nibble above the displayed digits catches values >= 10^DIGITS.
  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_WIDTH - 1);

  state_e                state_q, state_d;
  logic [BIN_WIDTH-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic                  carry_q, carry_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  overflow_q, overflow_d;
  logic [7*DIGITS-1:0]   digitos_q, digitos_d;

  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W-1:0]      bcd_step;
  logic [BIN_WIDTH-1:0]  bin_step;
  logic                  carry_step;
  logic                  ovf_final;
  logic [DIGITS-1:0]     blank;
  logic [7*DIGITS-1:0]   seg_next;

  // Double-dabble step: correct every nibble >= 5, then shift {bcd, bin}.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_step   = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
  assign bin_step   = bin_q << 1;
  assign carry_step = carry_q | bcd_adj[BCD_W-1];
  assign ovf_final  = carry_step | (|bcd_step[BCD_W-1 -: 4]);

  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (bcd_step[4*k +: 4] == 4'd0);
      blank[k]   = (BLANK_ZEROS != 0) && (k != 0) && zero_above;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    seg7_digit u_seg (
      .nibble_i (bcd_step[4*k +: 4]),
      .blank_i  (blank[k]),
      .seg_o    (seg_next[7*k +: 7])
    );
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    digitos_d  = digitos_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = bus.valor;
          bcd_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d   = bin_step;
        bcd_d   = bcd_step;
        carry_d = carry_step;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SHIFT) begin
          overflow_d = ovf_final;
          digitos_d  = ovf_final ? {DIGITS{SEG_DASH}} : seg_next;
          state_d    = LOAD;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      digitos_q  <= {DIGITS{SEG_BLANK}};
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      digitos_q  <= digitos_d;
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = (state_q == LOAD);
  assign bus.overflow = overflow_q;
  assign bus.digitos  = digitos_q;

endmodule

// File: tb/tb_bin2display_seq.sv
// Self-checking bench: three driver configurations share one stimulus stream
// and are compared against a decimal reference model.
module tb_bin2display_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] valor;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  bin2display_seq_if #(.BIN_WIDTH(10), .DIGITS(3)) if_a ();
  bin2display_seq_if #(.BIN_WIDTH(10), .DIGITS(3)) if_b ();
  bin2display_seq_if #(.BIN_WIDTH(10), .DIGITS(4)) if_c ();

  assign if_a.start = start;
  assign if_a.valor = valor;
  assign if_b.start = start;
  assign if_b.valor = valor;
  assign if_c.start = start;
  assign if_c.valor = valor;

  bin2display_seq #(.BIN_WIDTH(10), .DIGITS(3), .BLANK_ZEROS(1)) u_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  bin2display_seq #(.BIN_WIDTH(10), .DIGITS(3), .BLANK_ZEROS(0)) u_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));
  bin2display_seq #(.BIN_WIDTH(10), .DIGITS(4), .BLANK_ZEROS(1)) u_c (
    .clk(clk), .reset(reset), .bus(if_c.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0011000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Decimal reference: digit k = (v / 10^k) % 10; blanked when v < 10^k.
  function automatic logic [31:0] model_seg(input int v, input int digits, input bit blank);
    logic [31:0] r;
    logic [6:0]  s;
    int          p;
    int          lim;
    r   = '0;
    p   = 1;
    lim = 1;
    for (int k = 0; k < digits; k++) lim = lim * 10;
    for (int k = 0; k < digits; k++) begin
      if (v >= lim)                    s = 7'b0111111;
      else if (blank && k > 0 && v < p) s = 7'b1111111;
      else                             s = seg_of((v / p) % 10);
      r[7*k +: 7] = s;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check_outputs(input int v);
    check("a_done",    32'(if_a.done), 32'd1);
    check("a_busy",    32'(if_a.busy), 32'd0);
    check("a_ovf",     32'(if_a.overflow), 32'(v >= 1000));
    check("a_digitos", 32'(if_a.digitos), model_seg(v, 3, 1'b1));
    check("b_done",    32'(if_b.done), 32'd1);
    check("b_ovf",     32'(if_b.overflow), 32'(v >= 1000));
    check("b_digitos", 32'(if_b.digitos), model_seg(v, 3, 1'b0));
    check("c_done",    32'(if_c.done), 32'd1);
    check("c_ovf",     32'(if_c.overflow), 32'(v >= 10000));
    check("c_digitos", 32'(if_c.digitos), model_seg(v, 4, 1'b1));
  endtask

  // Caller is at a negedge in an IDLE cycle; noise drives ignored starts while busy.
  task automatic convert(input int v, input bit noise);
    int n;
    start = 1'b1;
    valor = 10'(v);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check("busy_after_start", 32'(if_a.busy), 32'd1);
    while (if_a.done !== 1'b1 && n < 40) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        valor = 10'($urandom_range(0, 1023));
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", 32'(n), 32'd11);
    check_outputs(v);
  endtask

  task automatic conv(input int v, input bit noise);
    @(negedge clk);
    check("done_single_pulse", 32'(if_a.done), 32'd0);
    convert(v, noise);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(if_a.busy), 32'd0);
    check({tag, "_done"}, 32'(if_a.done), 32'd0);
    check({tag, "_ovf"},  32'(if_a.overflow), 32'd0);
    check({tag, "_a_seg"}, 32'(if_a.digitos), (32'd1 << 21) - 32'd1);
    check({tag, "_b_seg"}, 32'(if_b.digitos), (32'd1 << 21) - 32'd1);
    check({tag, "_c_seg"}, 32'(if_c.digitos), (32'd1 << 28) - 32'd1);
    check({tag, "_c_busy"}, 32'(if_c.busy), 32'd0);
  endtask

  initial begin
    int n;
    int n_done;
    reset = 1'b1;
    start = 1'b0;
    valor = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    // Directed values: zero, blanking, full scale, overflow, recovery.
    conv(0, 1'b0);
    conv(42, 1'b0);
    conv(999, 1'b0);
    conv(1000, 1'b0);
    conv(7, 1'b0);

    // Second start at cycle 5 is ignored; only 100 is converted.
    @(negedge clk);
    start = 1'b1;
    valor = 10'd100;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    repeat (4) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    valor = 10'd200;
    @(negedge clk);
    n++;
    start = 1'b0;
    while (if_a.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ignored_start_latency", 32'(n), 32'd11);
    check_outputs(100);

    // Start held through LOAD: ignored there, accepted in the following IDLE cycle.
    start = 1'b1;
    valor = 10'd300;
    @(negedge clk);
    check("load_start_ignored", 32'(if_a.busy), 32'd0);
    check("done_low_after_load", 32'(if_a.done), 32'd0);
    convert(300, 1'b0);

    // Reset six cycles into a conversion of 512 aborts it.
    @(negedge clk);
    start = 1'b1;
    valor = 10'd512;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("abort");
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (if_a.done === 1'b1) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    conv(512, 1'b0);

    // Full 10-bit sweep.
    for (int v = 0; v < 1024; v++) conv(v, 1'b0);

    // Random values, random idle gaps and ignored starts while busy.
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      conv(int'($urandom_range(0, 1023)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
